// File: rtl/a2d_pkg.sv
// a2d_pkg: shared slot/state types and command-word builder for the A2D sequencer
package a2d_pkg;
  typedef enum logic [1:0] {SLOT_BATT, SLOT_CURR, SLOT_BRAKE, SLOT_TORQUE} slot_e;
  typedef enum logic [2:0] {IDLE, NEXT, CMD, GAP, READ} state_e;
  localparam logic [2:0] ADC_CH [4] = '{3'd0, 3'd1, 3'd3, 3'd4};
  function automatic logic [15:0] cmd_word(slot_e s);
    return {2'b00, ADC_CH[s], 11'h000};
  endfunction
endpackage

// File: rtl/a2d_sequencer_if.sv
// a2d_sequencer_if: transaction handshake between the sequencer and the SPI master
interface a2d_sequencer_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] resp;
  modport master (output wrt, cmd, input done, resp);
  modport slave (input wrt, cmd, output done, resp);
endinterface

// File: rtl/a2d_round_tmr.sv
// a2d_round_tmr: free-running round timer raising a pending flag on wrap or forced request
module a2d_round_tmr #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic force_cnv,
  input  logic clr,
  output logic pending
);
  localparam int W = FAST_SIM ? 10 : 14;
  logic [W-1:0] tmr_q, tmr_d;
  logic pending_q, pending_d;
  // a trigger on the clear clk wins so a request during round start is not lost
  always_comb begin
    tmr_d = tmr_q + 1'b1;
    pending_d = force_cnv | (&tmr_q) | (pending_q & ~clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tmr_q <= '0;
      pending_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      pending_q <= pending_d;
    end
  assign pending = pending_q;
endmodule

// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin scheduler of the four A2D channels over a shared SPI master
module a2d_sequencer
  import a2d_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  chnl_en,
  input  logic        force_cnv,
  a2d_sequencer_if.master spi,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        busy,
  output logic        cnv_cmplt
);
  state_e state_q, state_d;
  slot_e slot_q, slot_d, nxt_slot;
  logic [11:0] hold_q [4];
  logic [11:0] hold_d [4];
  logic cnv_cmplt_q, cnv_cmplt_d, pending, clr, nxt_found;
  a2d_round_tmr #(.FAST_SIM(FAST_SIM)) u_tmr (
    .clk(clk), .rst_n(rst_n), .force_cnv(force_cnv), .clr(clr), .pending(pending)
  );
  // IDLE picks the lowest enabled slot; mid-round only strictly higher slots qualify
  always_comb begin
    nxt_found = 1'b0;
    nxt_slot = slot_q;
    for (int i = 3; i >= 0; i--)
      if (chnl_en[i] && (state_q == IDLE || i > int'(slot_q))) begin
        nxt_found = 1'b1;
        nxt_slot = slot_e'(i[1:0]);
      end
  end
  assign clr = state_q == IDLE && pending;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q <= SLOT_BATT;
      hold_q <= '{default: '0};
      cnv_cmplt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      hold_q <= hold_d;
      cnv_cmplt_q <= cnv_cmplt_d;
    end
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    hold_d = hold_q;
    cnv_cmplt_d = 1'b0;
    case (state_q)
      IDLE: if (pending && nxt_found) begin
        state_d = NEXT;
        slot_d = nxt_slot;
      end
      NEXT: state_d = CMD;
      CMD:  state_d = spi.done ? GAP : CMD;
      GAP:  state_d = READ;
      READ: if (spi.done) begin
        hold_d[slot_q] = spi.resp[11:0];
        state_d = nxt_found ? NEXT : IDLE;
        slot_d = nxt_found ? nxt_slot : slot_q;
        cnv_cmplt_d = !nxt_found;
      end
      default: state_d = IDLE;
    endcase
  end
  // the same command word is sent twice; the second response carries the conversion
  always_comb begin
    spi.wrt = state_q == NEXT || state_q == GAP;
    spi.cmd = cmd_word(slot_q);
    busy = state_q != IDLE;
  end
  assign batt = hold_q[SLOT_BATT];
  assign curr = hold_q[SLOT_CURR];
  assign brake = hold_q[SLOT_BRAKE];
  assign torque = hold_q[SLOT_TORQUE];
  assign cnv_cmplt = cnv_cmplt_q;
endmodule

// File: tb/tb_a2d_sequencer.sv
// tb_a2d_sequencer: directed vectors and corner sequences for the A2D sequencer with an SPI stub
module tb_a2d_sequencer;
  logic clk, rst_n, force_cnv;
  logic [3:0] chnl_en;
  logic [11:0] batt, curr, brake, torque;
  logic busy, cnv_cmplt;
  a2d_sequencer_if spi();
  a2d_sequencer #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .chnl_en(chnl_en), .force_cnv(force_cnv), .spi(spi),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque), .busy(busy), .cnv_cmplt(cnv_cmplt)
  );
  typedef struct packed {
    logic [3:0]       en;
    logic [3:0][11:0] val;
    logic [3:0][11:0] exp;
  } vec_t;
  vec_t vecs [4];
  int total = 0, bad = 0;
  int wrt_cnt = 0, cmplt_cnt = 0, busy_cnt = 0;
  logic [15:0] cmd_log [$];
  int lat = 4, scnt = 0;
  bit wpar = 1'b0;
  logic [15:0] scmd = '0;
  logic [3:0][11:0] stub_val = '0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic [11:0] sval(input logic [15:0] c);
    case (c[13:11])
      3'd0: return stub_val[0];
      3'd1: return stub_val[1];
      3'd3: return stub_val[2];
      default: return stub_val[3];
    endcase
  endfunction
  // SPI stub: done after lat clks; the first of each pair returns junk in the low 12 bits
  always @(negedge clk) begin
    spi.done = 1'b0;
    if (scnt > 0) begin
      scnt--;
      if (scnt == 0) begin
        spi.done = 1'b1;
        spi.resp = wpar ? {4'hE, ~sval(scmd)} : {4'hA, sval(scmd)};
      end
    end
    if (spi.wrt === 1'b1) begin
      scnt = lat;
      scmd = spi.cmd;
      wpar = ~wpar;
    end
  end
  always @(negedge clk) begin
    if (spi.wrt === 1'b1) begin
      wrt_cnt++;
      cmd_log.push_back(spi.cmd);
    end
    if (cnv_cmplt === 1'b1) cmplt_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic pulse_force();
    @(negedge clk) force_cnv = 1'b1;
    @(negedge clk) force_cnv = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_batt"}, 32'(batt), 0);
    chk({tag, "_curr"}, 32'(curr), 0);
    chk({tag, "_brake"}, 32'(brake), 0);
    chk({tag, "_torque"}, 32'(torque), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_wrt"}, 32'(spi.wrt), 0);
    chk({tag, "_cmd"}, 32'(spi.cmd), 0);
    chk({tag, "_cmplt"}, 32'(cnv_cmplt), 0);
  endtask
  task automatic do_round(input vec_t v, input string tag);
    int c0, q0, t;
    int ch_of [4];
    logic [15:0] exp_cmd [$];
    ch_of = '{0, 1, 3, 4};
    stub_val = v.val;
    chnl_en = v.en;
    c0 = cmplt_cnt;
    q0 = cmd_log.size();
    pulse_force();
    t = 0;
    while (cmplt_cnt == c0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    chk({tag, "_finished"}, 32'(t < 400), 1);
    chk({tag, "_batt"}, 32'(batt), 32'(v.exp[0]));
    chk({tag, "_curr"}, 32'(curr), 32'(v.exp[1]));
    chk({tag, "_brake"}, 32'(brake), 32'(v.exp[2]));
    chk({tag, "_torque"}, 32'(torque), 32'(v.exp[3]));
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_cmplt_pulses"}, 32'(cmplt_cnt - c0), 1);
    for (int s = 0; s < 4; s++)
      if (v.en[s]) repeat (2) exp_cmd.push_back({2'b00, 3'(ch_of[s]), 11'h000});
    chk({tag, "_cmd_count"}, 32'(cmd_log.size() - q0), 32'(exp_cmd.size()));
    foreach (exp_cmd[i])
      if (q0 + i < cmd_log.size()) chk($sformatf("%s_cmd%0d", tag, i), 32'(cmd_log[q0 + i]), 32'(exp_cmd[i]));
  endtask
  initial begin
    int w0, c0, b0, t, first, second;
    vecs[0] = '{en: 4'hF, val: {12'hFFF, 12'h000, 12'h123, 12'h0F0}, exp: {12'hFFF, 12'h000, 12'h123, 12'h0F0}};
    vecs[1] = '{en: 4'hA, val: {12'h321, 12'h777, 12'hAAA, 12'h555}, exp: {12'h321, 12'h000, 12'hAAA, 12'h0F0}};
    vecs[2] = '{en: 4'h1, val: {12'h999, 12'h999, 12'h999, 12'h001}, exp: {12'h321, 12'h000, 12'hAAA, 12'h001}};
    vecs[3] = '{en: 4'h4, val: {12'h888, 12'h3C3, 12'h888, 12'h888}, exp: {12'h321, 12'h3C3, 12'hAAA, 12'h001}};
    rst_n = 1'b0;
    force_cnv = 1'b0;
    chnl_en = 4'h0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_round(vecs[i], $sformatf("vec%0d", i));
    // reset while the read-back transaction is outstanding; its late done must be ignored
    stub_val = {12'h444, 12'h333, 12'h222, 12'hABC};
    chnl_en = 4'hF;
    lat = 20;
    w0 = wrt_cnt;
    c0 = cmplt_cnt;
    pulse_force();
    t = 0;
    while (wrt_cnt < w0 + 2 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_read_reached", 32'(t < 100), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_in_read");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("late_done_batt", 32'(batt), 0);
    chk("late_done_busy", 32'(busy), 0);
    chk("late_done_wrts", 32'(wrt_cnt - w0), 2);
    chk("late_done_cmplt", 32'(cmplt_cnt - c0), 0);
    lat = 4;
    do_round(vecs[0], "post_rst");
    // two forces during a round merge into exactly one extra round
    do_reset();
    stub_val = vecs[0].val;
    chnl_en = 4'hF;
    w0 = wrt_cnt;
    c0 = cmplt_cnt;
    pulse_force();
    t = 0;
    while (wrt_cnt < w0 + 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    pulse_force();
    repeat (2) @(negedge clk);
    pulse_force();
    repeat (500) @(negedge clk);
    chk("dbl_force_cmplt", 32'(cmplt_cnt - c0), 2);
    chk("dbl_force_wrts", 32'(wrt_cnt - w0), 16);
    chk("dbl_force_busy", 32'(busy), 0);
    // no slots enabled: triggers are consumed silently
    do_reset();
    chnl_en = 4'h0;
    w0 = wrt_cnt;
    c0 = cmplt_cnt;
    b0 = busy_cnt;
    pulse_force();
    repeat (2000) @(negedge clk);
    chk("no_en_wrts", 32'(wrt_cnt - w0), 0);
    chk("no_en_cmplt", 32'(cmplt_cnt - c0), 0);
    chk("no_en_busy", 32'(busy_cnt - b0), 0);
    // timer-driven rounds only
    chnl_en = 4'hF;
    do_reset();
    first = 0;
    second = 0;
    for (int k = 1; k <= 2300 && second == 0; k++) begin
      @(negedge clk);
      if (spi.wrt === 1'b1 && first == 0) first = k;
      else if (spi.wrt === 1'b1 && k > first + 200) second = k;
    end
    chk("tmr_first_wrt_1025pm1", 32'(first >= 1024 && first <= 1026), 1);
    chk("tmr_period", 32'(second - first), 1024);
    repeat (100) @(negedge clk);
    chk("tmr_busy_after", 32'(busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/a2d_sequencer.md
Name: a2d_sequencer

Overview:
Scheduler that owns the shared A2D SPI master and sequences round-robin conversions of the four analog channels: battery, motor current, brake lever and pedal torque. It issues two-transaction ADC reads (command, then read-back) and keeps one holding register per channel. The sensor/torque math and telemetry downstream in eBike read these registers. It sits between the SPI master and the rest of eBike.

Parameters:
FAST_SIM, 1, selects round timer width: 1 gives 10 bits (1024 clk), 0 gives 14 bits (16384 clk).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
chnl_en  input  4  per-slot enable; bit0 BATT, bit1 CURR, bit2 BRAKE, bit3 TORQUE
force_cnv  input  1  one-clk pulse requesting an immediate round
wrt  output  1  one-clk pulse starting an SPI transaction
cmd  output  16  SPI word sent with wrt
done  input  1  one-clk pulse: SPI transaction finished
resp  input  16  SPI word received; valid when done
batt  output  12  latest battery reading
curr  output  12  latest current reading
brake  output  12  latest brake reading
torque  output  12  latest torque reading
busy  output  1  high from round start until round end
cnv_cmplt  output  1  one-clk pulse when a round finishes

Behaviour:
- Reset (asynchronous, any state) clears everything: outputs 0, FSM to IDLE, timer 0, pending 0, slot index 0. A transaction in flight is abandoned, and any done arriving afterward in IDLE is ignored.
- ADC channel map by slot: slot0 is ch0 (BATT), slot1 ch1 (CURR), slot2 ch3 (BRAKE), slot3 ch4 (TORQUE). Command word is {2'b00, ch[2:0], 11'h000}.
- Round timer:
  - Free-running, wraps to 0.
  - On wrap, or on force_cnv, the pending flag sets.
  - Pending clears on the clk the round starts. A trigger while busy sets pending, so exactly one extra round follows; further triggers merge into it.
- FSM states: IDLE, CMD, GAP, READ, NEXT.
  - IDLE: if pending and chnl_en != 0, go to NEXT with slot index = lowest enabled slot; busy goes high. If chnl_en == 0, pending clears, no transaction, no cnv_cmplt.
  - NEXT: assert wrt with the command for the current slot; go to CMD.
  - CMD: wait for done; then go to GAP.
  - GAP: one idle clk to allow SS_n deassert; then assert wrt with cmd = same command word (its response is the conversion) and go to READ.
  - READ: on done, latch resp[11:0] into the current slot's holding register on the clk done is high, so it is visible the next clk. Then:
    - if a higher enabled slot exists, advance the slot and go to NEXT;
    - else pulse cnv_cmplt, drop busy, and return to IDLE.
- wrt is only ever asserted one clk after NEXT/GAP is entered, and never while a transaction is outstanding.
- chnl_en is sampled at each slot advance. Disabling a slot mid-round skips it if not yet started; the in-progress slot always completes.
- Holding registers of disabled slots retain their last value.
- Per slot, latency from the wrt of the first transaction to the register update is 2 SPI transactions + 2 clk.
- done arriving in NEXT/GAP/IDLE is ignored.
- force_cnv and timer wrap in the same clk count as one trigger.

Decomposition:
- Shared package a2d_pkg:
  - slot enum (SLOT_BATT, SLOT_CURR, SLOT_BRAKE, SLOT_TORQUE);
  - ADC channel constant array {0,1,3,4};
  - FSM state enum;
  - function building the command word.
- The round timer plus pending-flag logic is a natural sub-module, a2d_round_tmr (parameter FAST_SIM; outputs pending; input clr).
- The SPI master stays external.

Test Plan:
- Reset, then force_cnv with chnl_en=4'hF; SPI stub returns 12'h0F0, 12'h123, 12'h000, 12'hFFF for ch 0/1/3/4 -> cmd sequence 0000,0000,0800,0800,1800,1800,2000,2000; registers batt 0F0, curr 123, brake 000, torque FFF; exactly one cnv_cmplt; busy low after.
- No force_cnv, FAST_SIM=1 -> first wrt 1025 clk (±1) after reset release; rounds repeat every 1024 clk when the SPI completes well inside a period.
- chnl_en=4'b1010 -> only commands 0800 and 2000 issued; batt/brake unchanged from their previous values.
- force_cnv pulsed twice mid-round -> exactly one additional round follows, total two cnv_cmplt pulses.
- chnl_en=0 plus force_cnv -> no wrt and no cnv_cmplt for 2000 clk; busy stays 0.
- rst_n asserted while in READ, with a late done afterward -> all outputs 0 immediately and the late done is ignored; the next forced round behaves as in the first scenario.
